sw_ctrl: RTL and testbench

- Button-conditioning and control stage directly upstream of the stopwatch display path.
- Synchronises and debounces three raw pushbuttons: start/stop, reset and lap.
- Runs the stopwatch mode FSM and drives the go and clr inputs of the stopwatch time logic.
- Drives a lap_hold level that the display path uses to freeze the shown digits while counting continues.

---
 rtl/sw_ctrl.sv | 137 +++++++++++++
 tb/tb_sw_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_ctrl.sv
// Stopwatch button conditioning and mode control: three synchronised, debounced
// pushbuttons drive the IDLE/RUN/STOP FSM and the go, clr and lap_hold levels.
module sw_ctrl #(
    parameter int unsigned DB_CYCLES = 2000000,
    parameter int unsigned CNT_W     = 21
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_ss,
    input  logic       btn_rst,
    input  logic       btn_lap,
    output logic       go,
    output logic       clr,
    output logic       lap_hold,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10
    } state_t;

    localparam int unsigned NB = 3;
    localparam int unsigned B_SS  = 0;
    localparam int unsigned B_RST = 1;
    localparam int unsigned B_LAP = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    s1_q, s1_d;
    logic [NB-1:0]    s2_q, s2_d;
    logic [NB-1:0]    db_q, db_d;
    logic [NB-1:0]    db_dly_q, db_dly_d;
    logic [NB-1:0]    press;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    state_t state_q, state_d;
    logic   go_q, go_d;
    logic   clr_q, clr_d;
    logic   lap_q, lap_d;

    assign raw = {btn_lap, btn_rst, btn_ss};

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        db_d     = db_q;
        db_dly_d = db_q;
        for (int unsigned i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            // Counter only runs while the synchronised level disagrees with db.
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = db_q & ~db_dly_q;

    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (press[B_SS]) begin
                    state_d = S_RUN;
                end else if (press[B_RST]) begin
                    clr_d = 1'b1;
                end
            end
            S_RUN: begin
                if (press[B_SS]) begin
                    state_d = S_STOP;
                    lap_d   = 1'b0;
                end else if (press[B_LAP]) begin
                    lap_d = ~lap_q;
                end
            end
            S_STOP: begin
                // Reset has priority over start/stop when both arrive together.
                if (press[B_RST]) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    lap_d   = 1'b0;
                end else if (press[B_SS]) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                lap_d   = 1'b0;
            end
        endcase
        go_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            state_q  <= S_IDLE;
            go_q     <= 1'b0;
            clr_q    <= 1'b1;
            lap_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q  <= state_d;
            go_q     <= go_d;
            clr_q    <= clr_d;
            lap_q    <= lap_d;
        end
    end

    assign go       = go_q;
    assign clr      = clr_q;
    assign lap_hold = lap_q;
    assign mode     = state_q;

endmodule

// File: tb/tb_sw_ctrl.sv
// Self-checking bench for sw_ctrl: directed scenarios with literal expectations
// plus randomized button activity compared every cycle against a behavioural model.
module tb_sw_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_rst = 1'b0;
    logic       btn_lap = 1'b0;
    logic       go, clr, lap_hold;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    sw_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .btn_ss   (btn_ss),
        .btn_rst  (btn_rst),
        .btn_lap  (btn_lap),
        .go       (go),
        .clr      (clr),
        .lap_hold (lap_hold),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buttons index 0=ss 1=rst 2=lap; mode 0 IDLE 1 RUN 2 STOP.
    bit m_seen1 [3];
    bit m_seen2 [3];
    bit m_db    [3];
    bit m_dbprev[3];
    int m_run   [3];
    bit m_ev    [3];
    bit m_raw   [3];
    int m_mode = 0;
    bit m_go = 0, m_clr = 1, m_lap = 0;

    task automatic model_step();
        if (!clr_n) begin
            for (int i = 0; i < 3; i++) begin
                m_seen1[i] = 0; m_seen2[i] = 0; m_db[i] = 0; m_dbprev[i] = 0; m_run[i] = 0;
            end
            m_mode = 0; m_go = 0; m_clr = 1; m_lap = 0;
        end else begin
            m_raw[0] = btn_ss; m_raw[1] = btn_rst; m_raw[2] = btn_lap;
            for (int i = 0; i < 3; i++) m_ev[i] = m_db[i] && !m_dbprev[i];
            m_clr = 0;
            if (m_mode == 0) begin
                if (m_ev[0]) m_mode = 1;
                else if (m_ev[1]) m_clr = 1;
            end else if (m_mode == 1) begin
                if (m_ev[0]) begin m_mode = 2; m_lap = 0; end
                else if (m_ev[2]) m_lap = !m_lap;
            end else begin
                if (m_ev[1]) begin m_mode = 0; m_clr = 1; m_lap = 0; end
                else if (m_ev[0]) m_mode = 1;
            end
            m_go = (m_mode == 1);
            for (int i = 0; i < 3; i++) begin
                m_dbprev[i] = m_db[i];
                // Level accepted once the synchronised input has disagreed for DB samples in a row.
                if (m_seen2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_db[i] = m_seen2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_seen2[i] = m_seen1[i];
                m_seen1[i] = m_raw[i];
            end
        end
    endtask

    always @(posedge clk or negedge clr_n) model_step();

    task automatic compare_all();
        chk("go", go, m_go);
        chk("clr", clr, m_clr);
        chk("lap_hold", lap_hold, m_lap);
        chk("mode", mode, m_mode);
    endtask

    always @(negedge clk) compare_all();

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input bit ss, input bit rst, input bit lap);
        btn_ss = ss; btn_rst = rst; btn_lap = lap;
    endtask

    task automatic press(input bit ss, input bit rst, input bit lap, input int hold);
        set_btn(ss, rst, lap);
        cyc(hold);
        set_btn(0, 0, 0);
        cyc(10);
    endtask

    task automatic press_cnt(input bit ss, input bit rst, input bit lap, output int n);
        n = 0;
        set_btn(ss, rst, lap);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clr === 1'b1) n++;
            if (i == 5) set_btn(0, 0, 0);
        end
    endtask

    initial begin
        int n;
        int hold;
        #1 clr_n = 1'b0;
        cyc(5);
        chk("rst_go", go, 0);
        chk("rst_clr", clr, 1);
        chk("rst_lap", lap_hold, 0);
        chk("rst_mode", mode, 0);
        clr_n = 1'b1;
        cyc(1);
        chk("clr_release", clr, 0);
        cyc(3);
        chk("clr_stays_low", clr, 0);

        // Start: go rises on the 7th edge counting the sampling edge.
        btn_ss = 1'b1;
        cyc(6);
        chk("lat_pre_go", go, 0);
        chk("lat_pre_mode", mode, 0);
        cyc(1);
        chk("lat_go", go, 1);
        chk("lat_mode", mode, 1);
        cyc(3);
        btn_ss = 1'b0;
        cyc(10);
        chk("held_single_event", mode, 1);

        press(1, 0, 0, 6);
        chk("stop_go", go, 0);
        chk("stop_mode", mode, 2);

        press_cnt(0, 1, 0, n);
        chk("stop_rst_clr_cycles", n, 1);
        chk("stop_rst_mode", mode, 0);

        press(1, 0, 0, 3);
        chk("glitch3_mode", mode, 0);
        chk("glitch3_go", go, 0);
        press(1, 0, 0, 4);
        chk("pulse4_mode", mode, 1);

        press(0, 0, 1, 6);
        chk("lap1_hold", lap_hold, 1);
        chk("lap1_go", go, 1);
        press(0, 0, 1, 6);
        chk("lap2_hold", lap_hold, 0);
        press(0, 0, 1, 6);
        chk("lap3_hold", lap_hold, 1);
        press(1, 0, 0, 6);
        chk("lap_then_stop_mode", mode, 2);
        chk("lap_then_stop_hold", lap_hold, 0);

        press(1, 0, 0, 6);
        press_cnt(0, 1, 0, n);
        chk("run_rst_clr_cycles", n, 0);
        chk("run_rst_mode", mode, 1);

        press(1, 0, 0, 6);
        chk("pre_simul_mode", mode, 2);
        press_cnt(1, 1, 0, n);
        chk("simul_clr_cycles", n, 1);
        chk("simul_mode", mode, 0);

        press(1, 0, 0, 6);
        chk("pre_abort_mode", mode, 1);
        btn_ss = 1'b1;
        cyc(3);
        #2 clr_n = 1'b0;
        #1;
        chk("abort_go", go, 0);
        chk("abort_clr", clr, 1);
        @(negedge clk);
        btn_ss = 1'b0;
        cyc(2);
        clr_n = 1'b1;
        cyc(12);
        chk("abort_mode", mode, 0);
        chk("abort_go_after", go, 0);

        hold = 0;
        repeat (3000) begin
            if (hold == 0) begin
                if ($urandom_range(0, 1) == 0)
                    {btn_lap, btn_rst, btn_ss} = 3'($urandom_range(0, 7));
                else
                    {btn_lap, btn_rst, btn_ss} = 3'(1 << $urandom_range(0, 2));
                clr_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
                hold = $urandom_range(1, 9);
            end
            hold--;
            cyc(1);
        end
        clr_n = 1'b1;
        set_btn(0, 0, 0);
        cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
